// File: rtl/interleaver_44bit_tx.sv
// Transmit-side 4x11 block interleaver: gathers four codewords, then emits a
// 44-bit frame with out_data[4c+r] = codeword_r[c] over a valid/ready handshake.
module interleaver_44bit_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] cw_in,
  input  logic        cw_valid,
  output logic        cw_ready,
  input  logic        flush,
  output logic [43:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [3:0][10:0] buf_q, buf_d;
  logic [1:0]       slot_q, slot_d;
  logic             coll_full_q, coll_full_d;
  logic [43:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic       out_free;
  logic       transfer;
  logic       accept;
  logic [1:0] wr_slot;
  logic [2:0] fill;
  logic       flush_take;

  function automatic logic [43:0] interleave(input logic [3:0][10:0] b);
    logic [43:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 11; c++)
        o[4*c + r] = b[r][c];
    return o;
  endfunction

  // Handshake terms; cw_ready deliberately looks through to out_ready so the
  // transfer cycle can also accept the first word of the next frame.
  assign out_free = !out_valid_q || out_ready;
  assign transfer = coll_full_q && out_free;
  assign cw_ready = !rst && (!coll_full_q || out_free);
  assign accept   = cw_valid && cw_ready;
  assign wr_slot  = transfer ? 2'd0 : slot_q;

  // Number of slots holding data once this cycle's accept (if any) lands.
  assign fill       = accept ? ({1'b0, wr_slot} + 3'd1) : {1'b0, slot_q};
  assign flush_take = flush && !coll_full_q && (fill != 3'd0) && (fill != 3'd4);

  // NOTE: combinational logic uses blocking assignments and assigns every
  // output a default first, so no path can leave a value held (no latch).
  always_comb begin
    buf_d       = buf_q;
    slot_d      = slot_q;
    coll_full_d = coll_full_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (transfer) begin
      out_data_d  = interleave(buf_q);
      out_valid_d = 1'b1;
      coll_full_d = 1'b0;
      slot_d      = 2'd0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      buf_d[wr_slot] = cw_in;
      if (wr_slot == 2'd3) begin
        coll_full_d = 1'b1;
        slot_d      = 2'd0;
      end else begin
        slot_d = wr_slot + 2'd1;
      end
    end

    // Close a partial frame: every slot at or beyond the fill point is padded.
    if (flush_take) begin
      for (int i = 0; i < 4; i++)
        if (3'(i) >= fill) buf_d[i] = '0;
      coll_full_d = 1'b1;
      slot_d      = 2'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments; the collect buffer is
  // reset along with the control state so no pre-reset codeword can ever leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      slot_q      <= 2'd0;
      coll_full_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      slot_q      <= slot_d;
      coll_full_q <= coll_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/interleaver_44bit_tx.md
# interleaver_44bit_tx

Transmit-side block interleaver for the modified Hamming datapath. It accepts 11-bit codewords one at a time over a valid/ready handshake and gathers four of them into a frame. It column-interleaves the frame so that a burst of up to 4 adjacent channel-bit errors touches each codeword at most once. The 44-bit interleaved frame is presented on a valid/ready output toward the channel. The receive-side deinterleaver applies the exact inverse mapping.

## Interface
- No parameters; widths are fixed at 4 codewords × 11 bits = 44 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cw_in`  in  11  codeword; bit 0 is codeword bit 0.
- `cw_valid`  in  1  `cw_in` is valid this cycle.
- `cw_ready`  out  1  block can accept `cw_in` this cycle.
- `flush`  in  1  single-cycle pulse; close a partial frame, zero-padding the unfilled slots.
- `out_data`  out  44  interleaved frame.
- `out_valid`  out  1  `out_data` holds a frame.
- `out_ready`  in  1  downstream consumes `out_data` when `out_valid` is also high.

## Operation
- **Collect buffer:** 4 slots of 11 bits, a 2-bit slot pointer `slot` (0..3), and a flag `coll_full`.
  - Codeword accepted in slot r occupies frame bits [11r+10 : 11r].
  - Slot 0 holds the first codeword accepted in the frame.
- **Interleave mapping:** `out_data[4c + r] = slot_r[c]` for r = 0..3 and c = 0..10.
- **Inverse mapping (receiver):** `frame[11r + c] = out_data[4c + r]`.
- **Output register:** holds `out_data` and `out_valid`. It is free when `out_valid` = 0, or when `out_valid` and `out_ready` are both high.
- **Transfer:** when `coll_full` = 1 and the output register is free:
  - `out_data` ← interleave(collect buffer);
  - `out_valid` ← 1;
  - `coll_full` ← 0;
  - `slot` ← 0.
- **Drain:** when `out_valid` and `out_ready` are high and no transfer occurs that cycle, `out_valid` ← 0. `out_data` holds its last value.
- **`cw_ready`** = !`rst` && (!`coll_full` || output register free). This is a combinational path from `out_ready` to `cw_ready`, and it is intended.
- **Accept:** occurs when `cw_valid` && `cw_ready`.
  - The codeword is written to slot `slot` (to slot 0 if a transfer occurs the same cycle).
  - `slot` increments.
  - An accept into slot 3 sets `coll_full` and wraps `slot` to 0.
- **Flush:**
  - If `flush` = 1, `coll_full` = 0, and at least one codeword is held (including one accepted this same cycle), the remaining slots are written with 0 and `coll_full` is set.
  - Flush is ignored when the buffer is empty.
  - Flush is ignored when `coll_full` = 1; no extra frame is created.
  - An accept into slot 3 together with `flush` behaves as a plain full frame.
- **Backpressure:** with `out_ready` held low, at most one frame sits in the output register and one in the collect buffer; `cw_ready` then stays 0.
- **Reset:**
  - `out_data` = 0, `out_valid` = 0, `slot` = 0, `coll_full` = 0, and all slots = 0.
  - `cw_ready` = 0 while `rst` is high.
  - Reset in the middle of a frame discards the partial and pending frames with no output.

## Timing
- If the 4th codeword is accepted at edge N, `coll_full` = 1 after edge N and `out_valid` = 1 after edge N+1, provided the output register is free in cycle N+1.
- Input-to-output latency is 2 cycles from the last codeword.
- Sustained throughput is 1 codeword per cycle when `out_ready` = 1: during the transfer cycle, `cw_ready` = 1 and the word goes into slot 0.
- `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
- `cw_ready` becomes 1 in the first cycle after `rst` deasserts.

## Test plan
- **Single-bit walk:** accept 0x7FF, 0x000, 0x000, 0x000 with `out_ready` = 1 → `out_valid` goes high 2 cycles after the last accept with `out_data` = 0x11111111111. With 0x7FF in slot 3 instead → 0x88888888888.
- **Streaming:** `cw_valid` held high for 8 random codewords with `out_ready` = 1 → two frames; `cw_ready` never drops; each frame satisfies the inverse mapping (`frame[11r+c] = out_data[4c+r]`) bit-exactly.
- **Backpressure:** `out_ready` = 0 while 8 codewords are offered → the first frame is held stable in the output register and `cw_ready` = 0 after the 8th accept. Raising `out_ready` → frame 1 is drained, frame 2 appears the next cycle, and `cw_ready` returns to 1.
- **Flush:** accept 0x555 and 0x2AA, then pulse `flush` → `out_data` = interleave(0x555, 0x2AA, 0, 0). Flush on an empty buffer → no frame. Flush together with an accept into slot 3 → exactly one frame.
- **Mid-frame reset:** accept 2 codewords, assert `rst` for 1 cycle → `out_valid` stays 0. The next 4 codewords produce a frame with no residue from before reset.
- **Burst-error property:** flip any 4 consecutive `out_data` bits → after de-interleaving, each 11-bit codeword differs from the original in at most 1 bit.
